line_mem_arbiter: RTL and testbench
===================================

Name: line_mem_arbiter

Overview:
- Shares the single line-read memory port between two line-fill requesters: port 0 is the instruction cache, port 1 is the data cache.
- Each cache issues a one-cycle miss pulse and then waits for the line. The arbiter latches each pulse, serialises the requests to memory with round-robin priority, and routes the returned line to the requester that owns it.
- Sits between the two cache instances and the memory model.
- Only one memory request is outstanding at any time.

Parameters:
- AddrWidth, 32, byte address width.
- ByteOffsetBits, 4, line offset bits; lines are 16 bytes.
- LineSize, 128, line width in bits.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_en_i  in  2  per-port one-cycle miss pulse; bit p belongs to port p
- req_addr_i  in  2 x AddrWidth  per-port miss address, valid when req_en_i[p] is high
- resp_valid_o  out  2  per-port one-cycle line-returned strobe
- resp_data_o  out  LineSize  returned line, shared by both ports, qualified by resp_valid_o
- mem_read_en_o  out  1  one-cycle read request to memory
- mem_addr_o  out  AddrWidth  line-aligned request address
- mem_read_valid_i  in  1  memory line-valid strobe
- mem_read_data_i  in  LineSize  memory line data
- err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset is asynchronous, active-low, on rstn_i; the clock is clk_i.
- Reset values: state IDLE, pend_valid = 2'b00, pend_addr = 0, rr_ptr = 0, owner = 0, err_o = 0. All outputs are 0 during and after reset.
- Capture:
  - When req_en_i[p] is high, set pend_valid[p] and load pend_addr[p] <= req_addr_i[p].
  - Both ports may capture in the same cycle.
- FSM IDLE:
  - If no pend_valid bit is set, stay in IDLE.
  - Otherwise grant: if exactly one pending, grant that port; if both pending, grant port rr_ptr.
  - In the grant cycle, assert mem_read_en_o = 1 and mem_addr_o = {pend_addr[g][AddrWidth-1:ByteOffsetBits], zeros}.
  - Register owner <= g and rr_ptr <= ~g, then go to BUSY.
- FSM BUSY:
  - mem_read_en_o = 0.
  - When mem_read_valid_i is high, combinationally drive resp_valid_o[owner] = 1 and resp_data_o = mem_read_data_i in that same cycle.
  - Clear pend_valid[owner] and go to IDLE.
- Latency: a pulse at cycle T gives mem_read_en_o at T+1 when the arbiter is IDLE with no competitor. The response is zero-cycle after mem_read_valid_i.
- The earliest next grant is the cycle after the completion; there is no back-to-back issue in the completion cycle.
- Requests pending while the arbiter is BUSY are held, never dropped.
- resp_data_o is 0 whenever resp_valid_o = 0.
- Boundary cases:
  - req_en_i[p] while pend_valid[p] is already set is a violation. The new request is ignored, the old address is kept, and err_o is set.
  - If req_en_i[owner] arrives in the same cycle as the owner's completion, the set wins: the line is delivered and the new request becomes pending.
  - mem_read_valid_i while in IDLE is ignored (no resp_valid_o) and sets err_o.
  - Reset mid-BUSY returns the block to IDLE with all pending cleared. A memory response arriving after reset falls under the IDLE case above.
  - err_o is sticky until reset.

Decomposition:
- Package mem_arb_pkg holds:
  - the ByteOffsetBits, LineSize and AddrWidth constants;
  - typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;
  - typedef logic port_id_t (1 bit).
- Sub-module rr_arbiter2 is natural:
  - inputs: the 2-bit pending vector and rr_ptr;
  - outputs: grant valid and grant id;
  - purely combinational, with rr_ptr kept in the parent.

Test Plan:
- Single port 0 miss: req_en_i = 01, addr 0x0000_1234 at T → mem_read_en_o = 1, mem_addr_o = 0x0000_1230 at T+1. Memory valid at T+4 with data 0xA5..A5 → resp_valid_o = 01, resp_data_o = 0xA5..A5 at T+4, nothing on port 1.
- Simultaneous misses after reset: req_en_i = 11, addr0 = 0x100, addr1 = 0x200 → first grant 0x100 (rr_ptr = 0). After its response, next cycle grant 0x200; the responses go to ports 0 then 1 respectively.
- Fairness: port 0 re-requests immediately after each response while port 1 stays pending → grants strictly alternate 0,1,0,1; port 1 is never starved.
- Request during BUSY: port 1 pulses addr 0x340 while port 0 is outstanding → held. mem_read_en_o with 0x340 appears exactly one cycle after port 0's completion.
- Violations: a second req_en_i[0] while port 0 is pending → err_o = 1, mem_addr_o stays at the first address. A separate run with mem_read_valid_i in IDLE → no resp_valid_o, err_o = 1.
- Reset mid-BUSY: assert rstn_i = 0 while BUSY, release, then pulse mem_read_valid_i → resp_valid_o = 00, state IDLE, err_o = 1, no spurious mem_read_en_o.

Source files
------------

// File: rtl/line_mem_arbiter_pkg.sv
// Shared constants and types for the two-port line-fill memory arbiter.
package mem_arb_pkg;

  localparam int AddrWidth      = 32;
  localparam int ByteOffsetBits = 4;
  localparam int LineSize       = 128;

  typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

  typedef logic port_id_t;

  function automatic logic [1:0] port_onehot(port_id_t p);
    return {p, ~p};
  endfunction

endpackage

// File: rtl/line_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant selector; the priority pointer lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] pend_i,
  input  logic       rr_ptr_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  assign gnt_valid_o = |pend_i;
  // A lone requester always wins; the pointer only breaks ties.
  assign gnt_id_o    = (pend_i == 2'b11) ? rr_ptr_i : pend_i[1];

endmodule

// File: rtl/line_mem_arbiter.sv
// Serialises instruction- and data-cache line fills onto one memory read port
// and routes each returned line back to the cache that asked for it.
module line_mem_arbiter #(
  parameter int AddrWidth      = mem_arb_pkg::AddrWidth,
  parameter int ByteOffsetBits = mem_arb_pkg::ByteOffsetBits,
  parameter int LineSize       = mem_arb_pkg::LineSize
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [1:0]             req_en_i,
  input  logic [2*AddrWidth-1:0] req_addr_i,
  output logic [1:0]             resp_valid_o,
  output logic [LineSize-1:0]    resp_data_o,
  output logic                   mem_read_en_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  input  logic                   mem_read_valid_i,
  input  logic [LineSize-1:0]    mem_read_data_i,
  output logic                   err_o
);

  import mem_arb_pkg::*;

  arb_state_t           state_q, state_d;
  logic [1:0]           pend_valid_q, pend_valid_d;
  logic [AddrWidth-1:0] pend_addr_q [2];
  logic [AddrWidth-1:0] pend_addr_d [2];
  port_id_t             rr_ptr_q, rr_ptr_d;
  port_id_t             owner_q, owner_d;
  logic                 err_q, err_d;

  logic       gnt_valid;
  port_id_t   gnt_id;
  logic       complete;
  logic [1:0] clr_mask;
  logic [1:0] held;
  logic [1:0] cap;
  logic [1:0] viol;
  logic       unused_addr_lsbs;

  rr_arbiter2 u_rr (
    .pend_i      (pend_valid_q),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign complete = (state_q == BUSY) && mem_read_valid_i;
  assign clr_mask = complete ? port_onehot(owner_q) : 2'b00;
  // A completing slot counts as free, so a same-cycle re-request is accepted.
  assign held     = pend_valid_q & ~clr_mask;
  assign viol     = req_en_i & held;
  assign cap      = req_en_i & ~held;

  assign mem_read_en_o = (state_q == IDLE) && gnt_valid;
  assign mem_addr_o    = mem_read_en_o
                       ? {pend_addr_q[gnt_id][AddrWidth-1:ByteOffsetBits], {ByteOffsetBits{1'b0}}}
                       : '0;
  assign resp_valid_o  = clr_mask;
  assign resp_data_o   = complete ? mem_read_data_i : '0;
  assign err_o         = err_q;

  assign unused_addr_lsbs = ^{pend_addr_q[0][ByteOffsetBits-1:0],
                              pend_addr_q[1][ByteOffsetBits-1:0]};

  always_comb begin
    pend_valid_d = held | cap;
    for (int p = 0; p < 2; p++) begin
      pend_addr_d[p] = cap[p] ? req_addr_i[p*AddrWidth +: AddrWidth] : pend_addr_q[p];
    end
    // Stray memory strobes in IDLE are dropped but remembered as errors.
    err_d    = err_q | (|viol) | ((state_q == IDLE) && mem_read_valid_i);
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = BUSY;
          owner_d  = gnt_id;
          rr_ptr_d = ~gnt_id;
        end
      end
      BUSY: begin
        if (mem_read_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      pend_valid_q   <= 2'b00;
      pend_addr_q[0] <= '0;
      pend_addr_q[1] <= '0;
      rr_ptr_q       <= 1'b0;
      owner_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_addr_q[0] <= pend_addr_d[0];
      pend_addr_q[1] <= pend_addr_d[1];
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      err_q          <= err_d;
    end
  end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed vector bench for line_mem_arbiter: one table row per clock cycle.
module tb_line_mem_arbiter;

  localparam int AW = 32;
  localparam int LS = 128;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [1:0]    req_en_i;
  logic [2*AW-1:0] req_addr_i;
  logic [1:0]    resp_valid_o;
  logic [LS-1:0] resp_data_o;
  logic          mem_read_en_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_read_valid_i;
  logic [LS-1:0] mem_read_data_i;
  logic          err_o;

  int checks = 0;
  int failures = 0;

  line_mem_arbiter dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .req_en_i         (req_en_i),
    .req_addr_i       (req_addr_i),
    .resp_valid_o     (resp_valid_o),
    .resp_data_o      (resp_data_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_addr_o       (mem_addr_o),
    .mem_read_valid_i (mem_read_valid_i),
    .mem_read_data_i  (mem_read_data_i),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        mv;
    logic [7:0]  md;
    logic        en;
    logic [31:0] addr;
    logic [1:0]  rv;
    logic [7:0]  rd;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [1:0] req, input logic [31:0] a0,
                     input logic [31:0] a1, input logic mv, input logic [7:0] md,
                     input logic en, input logic [31:0] addr, input logic [1:0] rv,
                     input logic [7:0] rd, input logic err);
    vec_t v;
    v.rst = rst; v.req = req; v.a0 = a0; v.a1 = a1; v.mv = mv; v.md = md;
    v.en = en; v.addr = addr; v.rv = rv; v.rd = rd; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [LS-1:0] act,
                     input logic [LS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] req, input logic [31:0] a0,
                       input logic [31:0] a1, input logic mv, input logic [7:0] md);
    rstn_i           = ~rst;
    req_en_i         = req;
    req_addr_i       = {a1, a0};
    mem_read_valid_i = mv;
    mem_read_data_i  = {16{md}};
  endtask

  task automatic check_outputs(input int row, input logic en, input logic [31:0] addr,
                               input logic [1:0] rv, input logic [7:0] rd, input logic err);
    logic [LS-1:0] exp_data;
    exp_data = {16{rd}};
    chk("mem_read_en", row, LS'(mem_read_en_o), LS'(en));
    chk("mem_addr", row, LS'(mem_addr_o), LS'(addr));
    chk("resp_valid", row, LS'(resp_valid_o), LS'(rv));
    chk("resp_data", row, resp_data_o, exp_data);
    chk("err", row, LS'(err_o), LS'(err));
    $display("row %0d: en=%0b addr=%h rv=%b data=%h err=%0b", row, mem_read_en_o,
             mem_addr_o, resp_valid_o, resp_data_o[7:0], err_o);
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 2 later.
  task automatic step(input int row, input logic rst, input logic [1:0] req,
                      input logic [31:0] a0, input logic [31:0] a1, input logic mv,
                      input logic [7:0] md, input logic en, input logic [31:0] addr,
                      input logic [1:0] rv, input logic [7:0] rd, input logic err);
    @(posedge clk_i);
    #2;
    drive(rst, req, a0, a1, mv, md);
    #2;
    check_outputs(row, en, addr, rv, rd, err);
  endtask

  initial begin
    //  rst req  a0          a1          mv md     en addr        rv    rd     err
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 0
    add(0, 2'b01, 32'h1234,   32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 1 T
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h1230,   2'b00, 8'h00, 0); // 2 T+1
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 3
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 4
    add(0, 2'b00, 32'h0,      32'h0,      1, 8'hA5, 0, 32'h0,      2'b01, 8'hA5, 0); // 5 T+4
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 6
    add(1, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 7 reset
    add(0, 2'b11, 32'h100,    32'h200,    0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 8
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h100,    2'b00, 8'h00, 0); // 9
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 10
    add(0, 2'b00, 32'h0,      32'h0,      1, 8'h11, 0, 32'h0,      2'b01, 8'h11, 0); // 11
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h200,    2'b00, 8'h00, 0); // 12
    add(0, 2'b00, 32'h0,      32'h0,      1, 8'h22, 0, 32'h0,      2'b10, 8'h22, 0); // 13
    add(0, 2'b11, 32'h400,    32'h500,    0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 14
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h400,    2'b00, 8'h00, 0); // 15
    add(0, 2'b01, 32'h410,    32'h0,      1, 8'h33, 0, 32'h0,      2'b01, 8'h33, 0); // 16
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h500,    2'b00, 8'h00, 0); // 17
    add(0, 2'b10, 32'h0,      32'h510,    1, 8'h44, 0, 32'h0,      2'b10, 8'h44, 0); // 18
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h410,    2'b00, 8'h00, 0); // 19
    add(0, 2'b01, 32'h420,    32'h0,      1, 8'h55, 0, 32'h0,      2'b01, 8'h55, 0); // 20
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h510,    2'b00, 8'h00, 0); // 21
    add(0, 2'b00, 32'h0,      32'h0,      1, 8'h66, 0, 32'h0,      2'b10, 8'h66, 0); // 22
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h420,    2'b00, 8'h00, 0); // 23
    add(0, 2'b10, 32'h0,      32'h340,    0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 24
    add(0, 2'b00, 32'h0,      32'h0,      1, 8'h77, 0, 32'h0,      2'b01, 8'h77, 0); // 25
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 1, 32'h340,    2'b00, 8'h00, 0); // 26
    add(0, 2'b00, 32'h0,      32'h0,      1, 8'h88, 0, 32'h0,      2'b10, 8'h88, 0); // 27
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 28
    add(0, 2'b01, 32'h600,    32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 0); // 29
    add(0, 2'b01, 32'h700,    32'h0,      0, 8'h00, 1, 32'h600,    2'b00, 8'h00, 0); // 30 violation
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 1); // 31
    add(0, 2'b00, 32'h0,      32'h0,      1, 8'h99, 0, 32'h0,      2'b01, 8'h99, 1); // 32
    add(0, 2'b00, 32'h0,      32'h0,      0, 8'h00, 0, 32'h0,      2'b00, 8'h00, 1); // 33

    drive(1, 2'b00, 32'h0, 32'h0, 0, 8'h00);
    repeat (2) @(posedge clk_i);
    #4;
    check_outputs(-1, 0, 32'h0, 2'b00, 8'h00, 0);

    foreach (vecs[i]) begin
      step(i, vecs[i].rst, vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].mv, vecs[i].md,
           vecs[i].en, vecs[i].addr, vecs[i].rv, vecs[i].rd, vecs[i].err);
    end

    // Reset while BUSY, then a stale memory strobe lands in IDLE.
    step(100, 1, 2'b00, 32'h0,   32'h0, 0, 8'h00, 0, 32'h0,   2'b00, 8'h00, 0);
    step(101, 0, 2'b01, 32'h808, 32'h0, 0, 8'h00, 0, 32'h0,   2'b00, 8'h00, 0);
    step(102, 0, 2'b00, 32'h0,   32'h0, 0, 8'h00, 1, 32'h800, 2'b00, 8'h00, 0);
    step(103, 1, 2'b00, 32'h0,   32'h0, 0, 8'h00, 0, 32'h0,   2'b00, 8'h00, 0);
    step(104, 0, 2'b00, 32'h0,   32'h0, 1, 8'hAA, 0, 32'h0,   2'b00, 8'h00, 0);
    step(105, 0, 2'b00, 32'h0,   32'h0, 0, 8'h00, 0, 32'h0,   2'b00, 8'h00, 1);
    step(106, 0, 2'b10, 32'h0,   32'h9F0, 0, 8'h00, 0, 32'h0, 2'b00, 8'h00, 1);
    step(107, 0, 2'b00, 32'h0,   32'h0, 0, 8'h00, 1, 32'h9F0, 2'b00, 8'h00, 1);
    step(108, 0, 2'b00, 32'h0,   32'h0, 1, 8'h5C, 0, 32'h0,   2'b10, 8'h5C, 1);
    // Only reset clears the sticky error.
    step(109, 1, 2'b00, 32'h0,   32'h0, 0, 8'h00, 0, 32'h0,   2'b00, 8'h00, 0);
    step(110, 0, 2'b00, 32'h0,   32'h0, 0, 8'h00, 0, 32'h0,   2'b00, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
